// File: rtl/ss_fifo.sv
// Beat buffer between the ADMA scatter-gather reader and writer: stores 64-bit beats and
// generates burst start/stop/end controls for both engines, plus sticky over/underflow flags.
module ss_fifo #(
    parameter int unsigned DW_LOG2 = 4,
    parameter int unsigned BURST   = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n,
    input  logic               ss_go,
    input  logic               ss_done,
    input  logic               r_xfer,
    input  logic               r_last,
    input  logic [63:0]        r_dat,
    output logic               r_start,
    output logic               r_stop,
    output logic               r_end,
    input  logic               w_xfer,
    output logic [63:0]        w_dat,
    output logic               w_start,
    output logic               w_stop,
    output logic               w_end,
    output logic [DW_LOG2:0]   f_cnt,
    output logic [1:0]         f_err,
    output logic               c_done
);

    localparam int unsigned        DEPTH     = 1 << DW_LOG2;
    localparam logic [DW_LOG2:0]   CNT_FULL  = (DW_LOG2 + 1)'(DEPTH);
    localparam logic [DW_LOG2:0]   CNT_BURST = (DW_LOG2 + 1)'(BURST);
    localparam logic [DW_LOG2:0]   CNT_ONE   = (DW_LOG2 + 1)'(1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_t;

    state_t               r_state;
    logic [DW_LOG2-1:0]   r_wr_ptr;
    logic [DW_LOG2-1:0]   r_rd_ptr;
    logic [DW_LOG2:0]     r_cnt;
    logic                 r_eof;
    logic [1:0]           r_err;
    logic [63:0]          r_mem [DEPTH];

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push_req;
    logic                 w_pop_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_marker;
    logic [DW_LOG2:0]     w_free;

    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CNT_FULL);
    assign w_free     = CNT_FULL - r_cnt;
    // ss_done outranks every push/pop in its cycle
    assign w_push_req = r_xfer & ~r_last & (r_state == StRun) & ~ss_done;
    assign w_marker   = r_xfer & r_last & (r_state == StRun) & ~ss_done;
    assign w_pop_req  = w_xfer & ((r_state == StRun) | (r_state == StDrain)) & ~ss_done;
    assign w_pop      = w_pop_req & ~w_empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts the beat
    assign w_push     = w_push_req & (~w_full | w_pop);

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_dat;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state  <= StIdle;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_eof    <= 1'b0;
            r_err    <= 2'b00;
        end else if (ss_done) begin
            r_state  <= StIdle;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_eof    <= 1'b0;
            r_err    <= 2'b00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_push_req && w_full && !w_pop) begin
                r_err[0] <= 1'b1;
            end
            if (w_pop_req && w_empty) begin
                r_err[1] <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (ss_go) begin
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (w_marker) begin
                        r_eof   <= 1'b1;
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (w_empty) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StDone;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign r_start = (r_state == StRun) & ~r_eof & (w_free >= CNT_BURST);
    assign r_stop  = (w_free <= CNT_ONE) | (r_state != StRun);
    assign r_end   = r_eof;
    assign w_start = ((r_state == StRun) & (r_cnt >= CNT_BURST))
                   | ((r_state == StDrain) & ~w_empty);
    assign w_stop  = (r_cnt <= CNT_ONE);
    assign w_end   = (r_state == StDone);
    assign w_dat   = r_mem[r_rd_ptr];
    assign f_cnt   = r_cnt;
    assign f_err   = r_err;
    assign c_done  = (r_state == StIdle) | (r_state == StDone);

endmodule

// File: tb/tb_ss_fifo.sv
// Bench for ss_fifo: vector table, directed corner sequences and a random run checked
// against a queue-based model of the buffer and its job states.
module tb_ss_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ss_go, ss_done, r_xfer, r_last, w_xfer;
    logic [63:0] r_dat;
    logic        r_start, r_stop, r_end, w_start, w_stop, w_end, c_done;
    logic [63:0] w_dat;
    logic [4:0]  f_cnt;
    logic [1:0]  f_err;

    always #5 clk = ~clk;

    ss_fifo #(.DW_LOG2(4), .BURST(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .ss_go    (ss_go),
        .ss_done  (ss_done),
        .r_xfer   (r_xfer),
        .r_last   (r_last),
        .r_dat    (r_dat),
        .r_start  (r_start),
        .r_stop   (r_stop),
        .r_end    (r_end),
        .w_xfer   (w_xfer),
        .w_dat    (w_dat),
        .w_start  (w_start),
        .w_stop   (w_stop),
        .w_end    (w_end),
        .f_cnt    (f_cnt),
        .f_err    (f_err),
        .c_done   (c_done)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: job state 0 idle, 1 run, 2 drain, 3 done; buffer contents as a queue
    logic [63:0] mq[$];
    int          mst;
    bit          meof;
    logic [1:0]  merr;

    typedef struct {
        bit go, done, rx, rl, wx;
        logic [63:0] rd;
        int cnt;
        logic [1:0] err;
        bit rs, rp, re, ws, wp, we, cd;
        bit wchk;
        logic [63:0] wd;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        mst  = 0;
        meof = 1'b0;
        merr = 2'b00;
    endfunction

    function automatic void model_step(bit go, bit done, bit rx, bit rl, bit wx,
                                       logic [63:0] rd);
        bit was_empty;
        if (done) begin
            model_reset();
            return;
        end
        was_empty = (mq.size() == 0);
        case (mst)
            0: if (go) mst = 1;
            1: begin
                if (wx) begin
                    if (was_empty) merr[1] = 1'b1;
                    else void'(mq.pop_front());
                end
                if (rx && rl) begin
                    meof = 1'b1;
                    mst  = 2;
                end else if (rx) begin
                    if (mq.size() < 16) mq.push_back(rd);
                    else merr[0] = 1'b1;
                end
            end
            2: begin
                if (wx) begin
                    if (was_empty) merr[1] = 1'b1;
                    else void'(mq.pop_front());
                end
                if (was_empty) mst = 3;
            end
            default: ;
        endcase
    endfunction

    task automatic apply(input bit go, input bit done, input bit rx, input bit rl,
                         input bit wx, input logic [63:0] rd);
        ss_go = go; ss_done = done; r_xfer = rx; r_last = rl; w_xfer = wx; r_dat = rd;
        @(posedge clk);
        model_step(go, done, rx, rl, wx, rd);
        #1;
    endtask

    task automatic check_model(input string tag);
        int c;
        int fr;
        c  = mq.size();
        fr = 16 - c;
        chk({tag, " f_cnt"},   f_cnt,   64'(c));
        chk({tag, " f_err"},   f_err,   merr);
        chk({tag, " r_start"}, r_start, (mst == 1 && !meof && fr >= 8));
        chk({tag, " r_stop"},  r_stop,  (fr <= 1 || mst != 1));
        chk({tag, " r_end"},   r_end,   meof);
        chk({tag, " w_start"}, w_start, ((mst == 1 && c >= 8) || (mst == 2 && c != 0)));
        chk({tag, " w_stop"},  w_stop,  (c <= 1));
        chk({tag, " w_end"},   w_end,   (mst == 3));
        chk({tag, " c_done"},  c_done,  (mst == 0 || mst == 3));
        if (c > 0) chk({tag, " w_dat"}, w_dat, mq[0]);
    endtask

    task automatic cyc(input string tag, input bit go, input bit done, input bit rx,
                       input bit rl, input bit wx, input logic [63:0] rd);
        apply(go, done, rx, rl, wx, rd);
        check_model(tag);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " f_cnt"},   f_cnt,   0);
        chk({tag, " f_err"},   f_err,   0);
        chk({tag, " r_start"}, r_start, 0);
        chk({tag, " r_stop"},  r_stop,  1);
        chk({tag, " r_end"},   r_end,   0);
        chk({tag, " w_start"}, w_start, 0);
        chk({tag, " w_stop"},  w_stop,  1);
        chk({tag, " w_end"},   w_end,   0);
        chk({tag, " c_done"},  c_done,  1);
    endtask

    initial begin
        //          go dn rx rl wx rd          cnt err   rs rp re ws wp we cd wchk wd
        tbl[0] = '{1, 0, 0, 0, 0, 64'h0,    0, 2'b00, 1, 0, 0, 0, 1, 0, 0, 0, 64'h0};
        tbl[1] = '{0, 0, 1, 0, 0, 64'h11,   1, 2'b00, 1, 0, 0, 0, 1, 0, 0, 1, 64'h11};
        tbl[2] = '{0, 0, 1, 0, 0, 64'h22,   2, 2'b00, 1, 0, 0, 0, 0, 0, 0, 1, 64'h11};
        tbl[3] = '{0, 0, 1, 0, 0, 64'h33,   3, 2'b00, 1, 0, 0, 0, 0, 0, 0, 1, 64'h11};
        tbl[4] = '{0, 0, 1, 1, 0, 64'hDEAD, 3, 2'b00, 0, 1, 1, 1, 0, 0, 0, 1, 64'h11};
        tbl[5] = '{0, 0, 0, 0, 1, 64'h0,    2, 2'b00, 0, 1, 1, 1, 0, 0, 0, 1, 64'h22};
        tbl[6] = '{0, 0, 0, 0, 1, 64'h0,    1, 2'b00, 0, 1, 1, 1, 1, 0, 0, 1, 64'h33};
        tbl[7] = '{0, 0, 0, 0, 1, 64'h0,    0, 2'b00, 0, 1, 1, 0, 1, 0, 0, 0, 64'h0};
        tbl[8] = '{0, 0, 0, 0, 0, 64'h0,    0, 2'b00, 0, 1, 1, 0, 1, 1, 1, 0, 64'h0};
        tbl[9] = '{0, 1, 0, 0, 0, 64'h0,    0, 2'b00, 0, 1, 0, 0, 1, 0, 1, 0, 64'h0};

        rst_n = 1'b0;
        ss_go = 0; ss_done = 0; r_xfer = 0; r_last = 0; w_xfer = 0; r_dat = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // End-of-chain job from the vector table
        for (int i = 0; i < 10; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            apply(tbl[i].go, tbl[i].done, tbl[i].rx, tbl[i].rl, tbl[i].wx, tbl[i].rd);
            chk({t, " f_cnt"},   f_cnt,   64'(tbl[i].cnt));
            chk({t, " f_err"},   f_err,   tbl[i].err);
            chk({t, " r_start"}, r_start, tbl[i].rs);
            chk({t, " r_stop"},  r_stop,  tbl[i].rp);
            chk({t, " r_end"},   r_end,   tbl[i].re);
            chk({t, " w_start"}, w_start, tbl[i].ws);
            chk({t, " w_stop"},  w_stop,  tbl[i].wp);
            chk({t, " w_end"},   w_end,   tbl[i].we);
            chk({t, " c_done"},  c_done,  tbl[i].cd);
            if (tbl[i].wchk) chk({t, " w_dat"}, w_dat, tbl[i].wd);
        end

        // Fill to 16, then an overflowing 17th beat
        cyc("fill go", 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            cyc("fill", 0, 0, 1, 0, 0, 64'(k));
            if (k == 8)  chk("fill r_start@8",  r_start, 1);
            if (k == 9)  chk("fill r_start@9",  r_start, 0);
            if (k == 14) chk("fill r_stop@14",  r_stop,  0);
            if (k == 15) chk("fill r_stop@15",  r_stop,  1);
        end
        chk("fill f_cnt16", f_cnt, 16);
        chk("fill f_err clean", f_err, 2'b00);
        cyc("fill ovf", 0, 0, 1, 0, 0, 64'h11);
        chk("ovf f_cnt", f_cnt, 16);
        chk("ovf f_err", f_err, 2'b01);
        chk("ovf head", w_dat, 64'h1);
        cyc("fill done", 0, 1, 0, 0, 0, 0);

        // Push and pop together on a full buffer; wr_ptr wraps to entry 0
        cyc("pp go", 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) cyc("pp fill", 0, 0, 1, 0, 0, 64'h100 + 64'(k));
        cyc("pp both", 0, 0, 1, 0, 1, 64'h1FF);
        chk("pp f_cnt", f_cnt, 16);
        chk("pp f_err", f_err, 2'b00);
        chk("pp head", w_dat, 64'h102);
        for (int j = 0; j < 16; j++) begin
            chk("pp order", w_dat, (j < 15) ? 64'h102 + 64'(j) : 64'h1FF);
            cyc("pp drain", 0, 0, 0, 0, 1, 0);
        end
        chk("pp empty", f_cnt, 0);
        cyc("pp done", 0, 1, 0, 0, 0, 0);

        // Streaming with pops one cycle behind pushes
        cyc("st go", 1, 0, 0, 0, 0, 0);
        for (int k = 0; k <= 16; k++) begin
            if (k >= 1) chk("st order", w_dat, 64'hA0 + 64'(k - 1));
            cyc("st", 0, 0, (k < 16), 0, (k >= 1), 64'hA0 + 64'(k));
            chk("st f_cnt<=2", (f_cnt <= 2), 1);
        end
        chk("st f_err", f_err, 2'b00);
        cyc("st done", 0, 1, 0, 0, 0, 0);

        // Underflow leaves rd_ptr in place; ss_done clears the flag
        cyc("uf go", 1, 0, 0, 0, 0, 0);
        cyc("uf pop", 0, 0, 0, 0, 1, 0);
        chk("uf f_err", f_err, 2'b10);
        cyc("uf push", 0, 0, 1, 0, 0, 64'h55);
        chk("uf head", w_dat, 64'h55);
        chk("uf f_cnt", f_cnt, 1);
        cyc("uf done", 0, 1, 0, 0, 0, 0);
        chk("uf cleared", f_err, 2'b00);

        // Asynchronous reset in the middle of a job
        cyc("rst go", 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc("rst fill", 0, 0, 1, 0, 0, 64'h70 + 64'(k));
        chk("rst f_cnt5", f_cnt, 5);
        #3 rst_n = 1'b0;
        #1;
        chk_reset("async rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model, in phases biased to fill and to drain
        for (int i = 0; i < 1500; i++) begin
            bit go, dn, rx, rl, wx;
            int ph;
            ph = (i / 100) % 3;
            go = (mst == 0) && ($urandom_range(3) == 0);
            dn = ($urandom_range(99) == 0) || (mst == 3 && $urandom_range(3) == 0);
            rx = $urandom_range(1);
            rl = rx && ($urandom_range(59) == 0);
            case (ph)
                0: wx = ($urandom_range(3) == 0);
                1: wx = ($urandom_range(3) != 0);
                default: wx = $urandom_range(1);
            endcase
            cyc("rnd", go, dn, rx, rl, wx, {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
